// File: rtl/hazard_unit_gen.sv
// -----------------------------------------------------------------------------
// hazard_unit_gen
//   Hazard unit for a 5-stage pipeline (F/D/E/M/W) that also has a multi-cycle
//   execute op. It produces:
//     - operand forwarding selects for the execute stage,
//     - load-use stall, control-hazard flush and multi-cycle busy stall,
//     - a sticky flag for a multi-cycle start that arrives while already busy,
//     - a saturating count of fetch-stall cycles.
//
// Parameters
//   AW       register-address width
//   MUL_LAT  execute-stage occupancy of a multi-cycle op (2..15)
//   CW       stall-counter width
//
// Ports
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low reset
//   RA1D, RA2D                  decode-stage source addresses
//   RA1E, RA2E                  execute-stage source addresses
//   WA3E, WA3M, WA3W            destination addresses in E/M/W
//   RegWriteE/M/W               register write enables in E/M/W
//   MemtoRegE                   execute-stage instruction is a load
//   PCSrcD/E/M/W                instruction in that stage writes the PC
//   BranchTakenE                branch resolved taken in execute
//   MulStartE                   one-cycle pulse: multi-cycle op entered execute
//   ForwardAE, ForwardBE        00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E, FlushD/E/M      pipeline-register controls
//   BusyE                       multi-cycle op in progress
//   ErrStart                    sticky: start pulse seen while busy
//   StallCount                  saturating count of StallF=1 cycles
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module hazard_unit_gen #(
  parameter int AW      = 4,
  parameter int MUL_LAT = 3,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic [AW-1:0] RA1E,
  input  logic [AW-1:0] RA2E,
  input  logic [AW-1:0] WA3E,
  input  logic [AW-1:0] WA3M,
  input  logic [AW-1:0] WA3W,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          PCSrcE,
  input  logic          PCSrcM,
  input  logic          PCSrcW,
  input  logic          BranchTakenE,
  input  logic          MulStartE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic          BusyE,
  output logic          ErrStart,
  output logic [CW-1:0] StallCount
);

  localparam int CNTW = $clog2(MUL_LAT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MUL_LAT - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [AW-1:0]   PC_ADDR  = '1;
  localparam logic [CW-1:0]   SAT_MAX  = '1;

  logic [0:0]      state;
  logic [CNTW-1:0] cnt;
  logic            err_start;
  logic [CW-1:0]   stall_count;

  logic ldrstall;
  logic pcpend;

  // Forwarding select for one execute-stage source. The newer result (M)
  // wins over the older one (W); reads of the PC register never forward.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] ra,
    input logic [AW-1:0] wa_m,
    input logic          we_m,
    input logic [AW-1:0] wa_w,
    input logic          we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != PC_ADDR) begin
      if (we_m && (wa_m == ra))      sel = 2'b10;
      else if (we_w && (wa_w == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
  assign ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);

  assign ldrstall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign pcpend   = PCSrcD | PCSrcE | PCSrcM;

  assign BusyE      = (state == BUSY);
  assign ErrStart   = err_start;
  assign StallCount = stall_count;

  // Pipeline controls. A running multi-cycle op freezes F/D/E and bubbles M,
  // overriding every other hazard term. Otherwise a taken branch flushes D
  // and E even when a load-use stall holds D in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (BusyE) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = ldrstall | pcpend;
      StallD = ldrstall;
      FlushD = pcpend | PCSrcW | BranchTakenE;
      FlushE = ldrstall | BranchTakenE;
    end
  end

  // Multi-cycle occupancy FSM. cnt is loaded with MUL_LAT-1 and the FSM
  // leaves BUSY on the edge where cnt==1, giving MUL_LAT-1 busy cycles.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      err_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MulStartE) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          // A second start while busy is dropped and only flagged.
          if (MulStartE) err_start <= 1'b1;
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating fetch-stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (StallF && (stall_count != SAT_MAX)) begin
      stall_count <= stall_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_gen.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_gen
//   Directed bench for hazard_unit_gen. Two instances share stimulus: one with
//   default parameters and one with a 4-bit stall counter for saturation.
//   A behavioural model tracks remaining busy cycles, the sticky error and the
//   stall counts; a compare process checks every output on each falling edge,
//   and the directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_unit_gen;

  localparam int AW      = 4;
  localparam int MUL_LAT = 3;

  logic          clk;
  logic          reset;
  logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE, ErrStart;
  logic [15:0] StallCount;

  logic [1:0]  fa4, fb4;
  logic        sf4, sd4, se4, fd4, fe4, fm4, busy4, err4;
  logic [3:0]  cnt4;

  hazard_unit_gen #(.AW(AW), .MUL_LAT(MUL_LAT), .CW(16)) u_dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .BusyE(BusyE), .ErrStart(ErrStart), .StallCount(StallCount)
  );

  hazard_unit_gen #(.AW(AW), .MUL_LAT(MUL_LAT), .CW(4)) u_dut_cw4 (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .StallF(sf4), .StallD(sd4), .StallE(se4),
    .FlushD(fd4), .FlushE(fe4), .FlushM(fm4),
    .BusyE(busy4), .ErrStart(err4), .StallCount(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, se, fd, fe, fm;
  } exp_t;

  int m_busy_left = 0;
  bit m_err       = 1'b0;
  int m_cnt16     = 0;
  int m_cnt4      = 0;

  function automatic logic [1:0] fwd_model(input logic [AW-1:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_of(input bit busy);
    exp_t e;
    bit ld, pc;
    ld = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    pc = PCSrcD || PCSrcE || PCSrcM;
    e.fa = fwd_model(RA1E);
    e.fb = fwd_model(RA2E);
    if (busy) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1; e.fd = 0; e.fe = 0;
    end else begin
      e.sf = ld || pc;
      e.sd = ld;
      e.se = 0;
      e.fm = 0;
      e.fd = pc || PCSrcW || BranchTakenE;
      e.fe = ld || BranchTakenE;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      m_busy_left <= 0;
      m_err       <= 1'b0;
      m_cnt16     <= 0;
      m_cnt4      <= 0;
    end else begin
      e = expect_of(m_busy_left > 0);
      if (e.sf) begin
        if (m_cnt16 < 65535) m_cnt16 <= m_cnt16 + 1;
        if (m_cnt4 < 15)     m_cnt4  <= m_cnt4 + 1;
      end
      if (m_busy_left > 0) begin
        if (MulStartE) m_err <= 1'b1;
        m_busy_left <= m_busy_left - 1;
      end else if (MulStartE) begin
        m_busy_left <= MUL_LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = expect_of(m_busy_left > 0);
      check("m_ForwardAE",  32'(ForwardAE),  32'(e.fa));
      check("m_ForwardBE",  32'(ForwardBE),  32'(e.fb));
      check("m_StallF",     32'(StallF),     32'(e.sf));
      check("m_StallD",     32'(StallD),     32'(e.sd));
      check("m_StallE",     32'(StallE),     32'(e.se));
      check("m_FlushD",     32'(FlushD),     32'(e.fd));
      check("m_FlushE",     32'(FlushE),     32'(e.fe));
      check("m_FlushM",     32'(FlushM),     32'(e.fm));
      check("m_BusyE",      32'(BusyE),      32'(m_busy_left > 0));
      check("m_ErrStart",   32'(ErrStart),   32'(m_err));
      check("m_StallCount", 32'(StallCount), 32'(m_cnt16));
      check("m_StallF_cw4", 32'(sf4),        32'(e.sf));
      check("m_BusyE_cw4",  32'(busy4),      32'(m_busy_left > 0));
      check("m_Count_cw4",  32'(cnt4),       32'(m_cnt4));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MulStartE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ldrstall();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_BusyE",      32'(BusyE),      0);
    check("rst_ErrStart",   32'(ErrStart),   0);
    check("rst_StallCount", 32'(StallCount), 0);

    @(posedge clk); #1 reset = 1'b1;

    // Forwarding priority and PC-register suppression
    tick(); RegWriteM = 1; WA3M = 4'd3; RA1E = 4'd3; RegWriteW = 1; WA3W = 4'd3;
    @(negedge clk); check("fwdA_M", 32'(ForwardAE), 32'b10);
    tick(); RegWriteM = 0;
    @(negedge clk); check("fwdA_W", 32'(ForwardAE), 32'b01);
    tick(); RA1E = 4'd15; WA3M = 4'd15; RegWriteM = 1;
    @(negedge clk); check("fwdA_pc", 32'(ForwardAE), 32'b00);
    tick(); RA2E = 4'd3;
    @(negedge clk); check("fwdB_W", 32'(ForwardBE), 32'b01);

    // Load-use stall for one cycle
    tick(); clear_inputs(); set_ldrstall();
    @(negedge clk);
    check("ld_StallF", 32'(StallF), 1);
    check("ld_StallD", 32'(StallD), 1);
    check("ld_FlushE", 32'(FlushE), 1);
    check("ld_cnt0",   32'(StallCount), 0);
    tick(); clear_inputs();
    @(negedge clk);
    check("ld_cnt1",   32'(StallCount), 1);

    // Multi-cycle op with a second start while busy
    tick(); MulStartE = 1;
    @(negedge clk); check("mul_c0_BusyE", 32'(BusyE), 0);
    tick(); MulStartE = 1; set_ldrstall(); BranchTakenE = 1;
    @(negedge clk);
    check("mul_c1_BusyE",  32'(BusyE),  1);
    check("mul_c1_StallE", 32'(StallE), 1);
    check("mul_c1_FlushM", 32'(FlushM), 1);
    check("mul_c1_FlushE", 32'(FlushE), 0);
    check("mul_c1_FlushD", 32'(FlushD), 0);
    tick(); clear_inputs();
    @(negedge clk);
    check("mul_c2_BusyE",  32'(BusyE),    1);
    check("mul_c2_Err",    32'(ErrStart), 1);
    tick();
    @(negedge clk);
    check("mul_c3_BusyE",  32'(BusyE),      0);
    check("mul_c3_cnt",    32'(StallCount), 3);

    // PC write advancing D->E->M->W
    tick(); PCSrcD = 1;
    @(negedge clk); check("pc_D_StallF", 32'(StallF), 1); check("pc_D_FlushD", 32'(FlushD), 1);
    tick(); PCSrcD = 0; PCSrcE = 1;
    @(negedge clk); check("pc_E_StallF", 32'(StallF), 1); check("pc_E_FlushD", 32'(FlushD), 1);
    tick(); PCSrcE = 0; PCSrcM = 1;
    @(negedge clk); check("pc_M_StallF", 32'(StallF), 1); check("pc_M_FlushD", 32'(FlushD), 1);
    tick(); PCSrcM = 0; PCSrcW = 1;
    @(negedge clk); check("pc_W_StallF", 32'(StallF), 0); check("pc_W_FlushD", 32'(FlushD), 1);
    check("pc_cnt", 32'(StallCount), 6);

    // Taken branch alone, then combined with a load-use stall
    tick(); clear_inputs(); BranchTakenE = 1;
    @(negedge clk);
    check("br_FlushD", 32'(FlushD), 1);
    check("br_FlushE", 32'(FlushE), 1);
    check("br_StallF", 32'(StallF), 0);
    tick(); MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA1D = 4'd5;
    @(negedge clk);
    check("brld_FlushE", 32'(FlushE), 1);
    check("brld_FlushD", 32'(FlushD), 1);
    check("brld_StallD", 32'(StallD), 1);

    // Long stall: 4-bit counter saturates at 15
    tick(); clear_inputs(); set_ldrstall();
    repeat (20) tick();
    @(negedge clk);
    check("sat_cw4", 32'(cnt4), 15);

    // Reset during BUSY aborts immediately
    tick(); clear_inputs(); MulStartE = 1;
    tick(); MulStartE = 0;
    @(negedge clk); check("rb_busy_pre", 32'(BusyE), 1);
    #2 reset = 1'b0;
    #1;
    check("rb_BusyE",  32'(BusyE),      0);
    check("rb_StallE", 32'(StallE),     0);
    check("rb_StallF", 32'(StallF),     0);
    check("rb_cnt",    32'(StallCount), 0);
    check("rb_cnt4",   32'(cnt4),       0);

    // First edge after reset release accepts a start
    @(posedge clk); #1 reset = 1'b1; MulStartE = 1;
    @(negedge clk); check("rs_c0_BusyE", 32'(BusyE), 0);
    tick(); MulStartE = 0;
    @(negedge clk); check("rs_c1_BusyE", 32'(BusyE), 1);
    tick();
    @(negedge clk); check("rs_c2_BusyE", 32'(BusyE), 1);
    tick();
    @(negedge clk); check("rs_c3_BusyE", 32'(BusyE), 0);
    check("rs_Err", 32'(ErrStart), 0);

    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit_gen.md
HAZARD_UNIT_GEN -- requirements
Module: hazard_unit_gen

Interface
REQ-001 Parameter AW, default 4: register-address width.
REQ-002 Parameter MUL_LAT, default 3, legal range 2..15: execute-stage occupancy in cycles of a multi-cycle op.
REQ-003 Parameter CW, default 16: stall-counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately.
REQ-006 RA1D, RA2D  in  AW  decode-stage source addresses; RA1E, RA2E  in  AW  execute-stage source addresses.
REQ-007 WA3E, WA3M, WA3W  in  AW  destination addresses per stage; RegWriteE/M/W  in  1  write enables per stage.
REQ-008 MemtoRegE  in  1  execute-stage instruction is a load.
REQ-009 PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction in that stage writes the PC.
REQ-010 BranchTakenE  in  1  branch resolved taken in execute.
REQ-011 MulStartE  in  1  one-cycle pulse: multi-cycle op entered execute.
REQ-012 ForwardAE, ForwardBE  out  2  00=register file, 01=ResultW, 10=ALUOutM.
REQ-013 StallF, StallD, StallE, FlushD, FlushE, FlushM  out  1  pipeline-register controls.
REQ-014 BusyE  out  1  multi-cycle op in progress; ErrStart  out  1  sticky illegal-start flag.
REQ-015 StallCount  out  CW  count of cycles with StallF=1.

Function
REQ-016 ForwardAE SHALL be 10 if RegWriteM and WA3M==RA1E; else 01 if RegWriteW and WA3W==RA1E; else 00. ForwardBE SHALL follow the same rule with RA2E.
REQ-017 Forwarding SHALL be suppressed (00) when the matching source address is all-ones (PC register).
REQ-018 ldrstall SHALL be MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D), combinational.
REQ-019 pcpend SHALL be PCSrcD | PCSrcE | PCSrcM.
REQ-020 The FSM SHALL have exactly the states IDLE and BUSY, with a counter cnt of width ceil(log2(MUL_LAT)).
REQ-021 In IDLE, MulStartE=1 SHALL move to BUSY with cnt=MUL_LAT-1 on the next edge.
REQ-022 In BUSY, cnt SHALL decrement each cycle, and the FSM SHALL return to IDLE on the edge where cnt==1. Total BusyE-high cycles SHALL be MUL_LAT-1.
REQ-023 BusyE SHALL be high exactly when state==BUSY.
REQ-024 A MulStartE pulse while BUSY SHALL be ignored and SHALL set ErrStart on the next edge. ErrStart SHALL clear only on reset.
REQ-025 While BusyE=1: StallF=StallD=StallE=1, FlushM=1, FlushE=0, FlushD=0. BusyE SHALL take priority over all other terms.
REQ-026 While BusyE=0: StallF=ldrstall|pcpend, StallD=ldrstall, StallE=0, FlushM=0.
REQ-027 While BusyE=0: FlushD=pcpend|PCSrcW|BranchTakenE and FlushE=ldrstall|BranchTakenE.
REQ-028 When ldrstall and BranchTakenE are both high, the block SHALL assert FlushE, FlushD and StallD together; the flush of the wrong-path instruction dominates.
REQ-029 StallCount SHALL increment on every edge where StallF=1, and SHALL saturate at all-ones without wrapping.
REQ-030 All outputs except ForwardAE/BE SHALL be glitch-free functions of registered state plus the listed combinational terms. No output depends on clk level.

Reset
REQ-031 While reset=0: state=IDLE, cnt=0, BusyE=0, ErrStart=0, StallCount=0. Combinational outputs follow REQ-016..027 with BusyE=0.
REQ-032 Reset asserted mid-BUSY SHALL abort the op immediately, dropping BusyE and the busy stalls asynchronously.
REQ-033 On the first edge after reset deasserts, the block SHALL accept MulStartE normally.

Verification
REQ-034 RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; then RA1E=15, WA3M=15, RegWriteM=1 -> ForwardAE=00.
REQ-035 MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=1, StallD=1, FlushE=1 for one cycle; StallCount 0->1.
REQ-036 MUL_LAT=3, MulStartE pulse -> BusyE high 2 cycles, StallE=1 and FlushM=1 in those cycles, IDLE on cycle 3; a second pulse during BUSY -> ErrStart=1 and busy length unchanged.
REQ-037 PCSrcD=1 advancing D->E->M->W over 4 cycles -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles; BranchTakenE=1 alone -> FlushD=FlushE=1.
REQ-038 CW=4, StallF held high 20 cycles -> StallCount reaches 15 and holds; reset=0 asserted during BUSY -> BusyE=0 and StallCount=0 before the next edge.
